pg_domain_sequencer: RTL
========================

Name: pg_domain_sequencer

Overview:
- Power-gating controller for one gateable core domain, e.g. an execution lane or a FIFO partition.
- Sequences the header power switch, the domain-local reset and the isolation clamp enable.
- Its clampEn output drives the clamp enable of every isolation cell on the domain boundary.
- Guarantees three orderings: clamp asserted before power removal; clamp released only after power is good and domain reset completes; no power-down while the domain is busy.

Parameters:
- CLAMP_SETUP, default 2: cycles clampEn is held before sleepEn asserts.
- WAKE_SETTLE, default 16: minimum cycles after sleepEn deasserts before pwrGood is accepted.
- RESET_HOLD, default 4: cycles domainReset is held after power is good.
- PG_TIMEOUT, default 255: cycles allowed for a pwrGood edge before pgError is set.
- RESET_ON, default 0: 1 = domain powered and unclamped out of reset; 0 = domain off and clamped.
- CNT_W, default 8: counter width; must satisfy CNT_W >= clog2(max of the four cycle parameters + 1).

Ports:
- clk  in  1  core clock
- resetN  in  1  asynchronous active-low reset
- powerReq  in  1  1 = domain requested on; level-sensitive
- domainBusy  in  1  1 = domain holds in-flight state; blocks power-down
- pwrGood  in  1  power switch ack; 1 = rail up; already synchronized
- sleepEn  out  1  1 = header switch off
- clampEn  out  1  1 = isolation cells clamp domain outputs
- domainReset  out  1  active-high reset into gated domain
- powerOn  out  1  1 = domain usable (state ON only)
- seqBusy  out  1  1 = any state other than ON or OFF
- pgError  out  1  sticky; pwrGood edge not seen within PG_TIMEOUT

Behaviour:
- All outputs are registered and decoded from state; there are no combinational input-to-output paths.
- One cycle of latency from input sample to output change.
- Asynchronous reset, any time including mid-sequence, forces the reset state immediately. Counter = 0, pgError = 0.
- Reset state, RESET_ON=0: OFF, with sleepEn=1, clampEn=1, domainReset=1, powerOn=0.
- Reset state, RESET_ON=1: ON, with sleepEn=0, clampEn=0, domainReset=0, powerOn=1.
- Output values per state, listed as sleepEn/clampEn/domainReset:
  - OFF 1/1/1
  - WAKE_SW 0/1/1
  - WAKE_RST 0/1/1
  - WAKE_REL 0/1/0
  - ON 0/0/0
  - DRAIN 0/0/0
  - CLAMP 0/1/0
  - SLEEP 1/1/1
- Transitions:
  - OFF -> WAKE_SW when powerReq=1. Counter cleared.
  - WAKE_SW -> WAKE_RST when counter >= WAKE_SETTLE-1 and pwrGood=1. Counter cleared.
  - WAKE_RST -> WAKE_REL when counter == RESET_HOLD-1. This gives exactly RESET_HOLD cycles of domainReset in WAKE_RST.
  - WAKE_REL -> ON unconditionally. This provides one cycle of reset-released, still-clamped settle.
  - ON -> DRAIN when powerReq=0.
  - DRAIN -> ON when powerReq=1 (abort; clamp never asserted).
  - DRAIN -> CLAMP when powerReq=0 and domainBusy=0. Counter cleared.
  - CLAMP -> SLEEP when counter == CLAMP_SETUP-1.
  - SLEEP -> OFF when pwrGood=0.
- Wake sequence (WAKE_*) is non-abortable: a powerReq drop there is serviced only after reaching ON.
- CLAMP and SLEEP are non-abortable: a powerReq rise there is serviced from OFF.
- Counter increments every cycle in a counting state and saturates at all-ones; it must never wrap.
- Timeout:
  - Applies in WAKE_SW (waiting for pwrGood=1) and SLEEP (waiting for pwrGood=0).
  - A separate wait counter cleared on state entry; pgError sets when it reaches PG_TIMEOUT.
  - The state does not change on timeout; the sequencer keeps waiting. pgError clears only on reset.
- Simultaneous powerReq=0 and domainBusy=0 in ON: go to DRAIN, then CLAMP the next cycle.
- pwrGood=1 arriving before WAKE_SETTLE expires is held off until the settle count completes.

Decomposition:
- Shared package pg_pkg holds:
  - the pgState_t enum (OFF, WAKE_SW, WAKE_RST, WAKE_REL, ON, DRAIN, CLAMP, SLEEP);
  - per-state output constants.
- Sub-module pg_sat_counter: CNT_W-bit saturating counter with clear and enable. It is instantiated twice, once for the phase count and once for the timeout.
- FSM and output decode remain in the top level.

Test Plan:
- RESET_ON=0, release resetN, powerReq=1 at cycle 2, pwrGood=1 at cycle 5:
  - sleepEn falls at cycle 3.
  - With WAKE_SETTLE=16, WAKE_RST is entered at cycle 19.
  - domainReset is high exactly 4 cycles in WAKE_RST.
  - clampEn falls 1 cycle after domainReset falls; powerOn=1 the same cycle.
- From ON, powerReq=0 with domainBusy=1 for 10 cycles:
  - Remains in DRAIN with clampEn=0.
  - After domainBusy drops: clampEn=1 next cycle, sleepEn=1 exactly 2 cycles later.
- Drop pwrGood 3 cycles after sleepEn rises:
  - Reaches OFF at cycle 4 with domainReset=1.
- From DRAIN, raise powerReq:
  - Returns to ON next cycle; clampEn never asserted.
- Hold pwrGood=0 in WAKE_SW:
  - pgError rises at wait count 255 and stays in WAKE_SW.
  - Raise pwrGood: wake completes and pgError stays 1.
- Assert resetN=0 mid-CLAMP:
  - Outputs go to the reset state asynchronously, before the next edge.
  - Repeat with RESET_ON=1: outputs go to ON values, powerOn=1.

Source files
------------

// File: rtl/pg_pkg.sv
// Shared types and per-state output decode for the power-gating domain sequencer.
package pg_pkg;

    typedef enum logic [2:0] {
        StOff,
        StWakeSw,
        StWakeRst,
        StWakeRel,
        StOn,
        StDrain,
        StClamp,
        StSleep
    } pgState_t;

    typedef struct packed {
        logic sleep_en;
        logic clamp_en;
        logic domain_reset;
    } pg_out_t;

    localparam pg_out_t OutOff     = '{sleep_en: 1'b1, clamp_en: 1'b1, domain_reset: 1'b1};
    localparam pg_out_t OutWakeSw  = '{sleep_en: 1'b0, clamp_en: 1'b1, domain_reset: 1'b1};
    localparam pg_out_t OutWakeRst = '{sleep_en: 1'b0, clamp_en: 1'b1, domain_reset: 1'b1};
    localparam pg_out_t OutWakeRel = '{sleep_en: 1'b0, clamp_en: 1'b1, domain_reset: 1'b0};
    localparam pg_out_t OutOn      = '{sleep_en: 1'b0, clamp_en: 1'b0, domain_reset: 1'b0};
    localparam pg_out_t OutDrain   = '{sleep_en: 1'b0, clamp_en: 1'b0, domain_reset: 1'b0};
    localparam pg_out_t OutClamp   = '{sleep_en: 1'b0, clamp_en: 1'b1, domain_reset: 1'b0};
    localparam pg_out_t OutSleep   = '{sleep_en: 1'b1, clamp_en: 1'b1, domain_reset: 1'b1};

    function automatic pg_out_t pg_decode(input pgState_t st);
        pg_out_t o;
        unique case (st)
            StOff:     o = OutOff;
            StWakeSw:  o = OutWakeSw;
            StWakeRst: o = OutWakeRst;
            StWakeRel: o = OutWakeRel;
            StOn:      o = OutOn;
            StDrain:   o = OutDrain;
            StClamp:   o = OutClamp;
            StSleep:   o = OutSleep;
            default:   o = OutOff;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pg_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module pg_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pg_domain_sequencer.sv
// Power-gating sequencer for one core domain: orders header switch, domain reset and
// isolation clamp so the clamp always brackets the unpowered interval.
module pg_domain_sequencer
    import pg_pkg::*;
#(
    parameter int unsigned CLAMP_SETUP = 2,
    parameter int unsigned WAKE_SETTLE = 16,
    parameter int unsigned RESET_HOLD  = 4,
    parameter int unsigned PG_TIMEOUT  = 255,
    parameter bit          RESET_ON    = 1'b0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic resetN,
    input  logic powerReq,
    input  logic domainBusy,
    input  logic pwrGood,
    output logic sleepEn,
    output logic clampEn,
    output logic domainReset,
    output logic powerOn,
    output logic seqBusy,
    output logic pgError
);

    localparam pgState_t ResetState = RESET_ON ? StOn : StOff;

    // Last count value of each phase; a zero parameter degenerates to a single cycle.
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(WAKE_SETTLE > 0 ? WAKE_SETTLE - 1 : 0);
    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RESET_HOLD > 0 ? RESET_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] SetupLast  = CNT_W'(CLAMP_SETUP > 0 ? CLAMP_SETUP - 1 : 0);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(PG_TIMEOUT);

    pgState_t         state_d, state_q;
    logic             pg_error_d, pg_error_q;
    logic [CNT_W-1:0] phase_cnt, wait_cnt;
    logic             state_change, phase_en, wait_en;
    pg_out_t          outs;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff:     if (powerReq) state_d = StWakeSw;
            StWakeSw:  if (pwrGood && (phase_cnt >= SettleLast)) state_d = StWakeRst;
            StWakeRst: if (phase_cnt >= HoldLast) state_d = StWakeRel;
            StWakeRel: state_d = StOn;
            StOn:      if (!powerReq) state_d = StDrain;
            StDrain: begin
                if (powerReq) begin
                    state_d = StOn;
                end else if (!domainBusy) begin
                    state_d = StClamp;
                end
            end
            StClamp:   if (phase_cnt >= SetupLast) state_d = StSleep;
            StSleep:   if (!pwrGood) state_d = StOff;
            default:   state_d = ResetState;
        endcase
    end

    // Both counters restart on every state change, so each phase counts from zero.
    assign state_change = (state_d != state_q);
    assign phase_en     = (state_q == StWakeSw) || (state_q == StWakeRst) || (state_q == StClamp);
    assign wait_en      = (state_q == StWakeSw) || (state_q == StSleep);

    pg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk_i  (clk),
        .rst_ni (resetN),
        .clr_i  (state_change),
        .en_i   (phase_en),
        .cnt_o  (phase_cnt)
    );

    pg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk_i  (clk),
        .rst_ni (resetN),
        .clr_i  (state_change),
        .en_i   (wait_en),
        .cnt_o  (wait_cnt)
    );

    always_comb begin
        pg_error_d = pg_error_q;
        if (wait_en && (wait_cnt >= TimeoutCnt)) begin
            pg_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ResetState;
            pg_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pg_error_q <= pg_error_d;
        end
    end

    always_comb begin
        outs        = pg_decode(state_q);
        sleepEn     = outs.sleep_en;
        clampEn     = outs.clamp_en;
        domainReset = outs.domain_reset;
        powerOn     = (state_q == StOn);
        seqBusy     = (state_q != StOn) && (state_q != StOff);
        pgError     = pg_error_q;
    end

endmodule
